// File: rtl/mem_pkg.sv
// Shared constants, state type and load-lane extraction for the memory stage.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RESP = 2'd2
  } state_t;

  // Pick the addressed byte/halfword out of a memory word and extend it.
  // Reserved funct3 codes fall through to the full word.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'b0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_memory_p.sv
// Word-organised data RAM with per-byte write enables and a registered read.
// Contents are deliberately not reset.
module data_memory_p #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-lane writes and synchronous read share one address port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_stage_p.sv
// EX->WB memory-access stage: sub-word loads/stores, misalignment
// suppression, ALU pass-through and a valid/ready handshake on each side.
module mem_stage_p
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int TAG_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_memRead,
  input  logic              is_memWrite,
  input  logic [2:0]        funct3,
  input  logic [31:0]       address,
  input  logic [31:0]       S_data,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       data_out,
  output logic              misaligned,
  output logic [TAG_W-1:0]  tag_out
);

  localparam int AW = $clog2(DEPTH_WORDS);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("mem_stage_p: only DATA_W = 32 is supported");
  end
  if ((DEPTH_WORDS < 1) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
    $error("mem_stage_p: DEPTH_WORDS must be a power of two");
  end

  state_t           state_q, state_d;
  logic [31:0]      data_q, data_d;
  logic             mis_q, mis_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;

  logic        accept;
  logic        is_byte, is_half, aligned;
  logic        do_store, do_load;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;
  logic [31:0] mem_rdata;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == RESP);
  assign data_out  = data_q;
  assign misaligned = mis_q;
  assign tag_out   = tag_q;

  assign is_byte = (funct3 == F3_B) || (funct3 == F3_BU);
  assign is_half = (funct3 == F3_H) || (funct3 == F3_HU);
  assign aligned = is_byte ? 1'b1 :
                   is_half ? ~address[0] :
                             (address[1:0] == 2'b00);

  // Writes take priority over reads when both are flagged.
  assign do_store = accept && is_memWrite && aligned;
  assign do_load  = accept && !is_memWrite && is_memRead && aligned;

  // Steer store data into the addressed byte lanes.
  always_comb begin
    lane_we    = 4'b0000;
    lane_wdata = S_data;
    if (is_byte) begin
      lane_wdata = {4{S_data[7:0]}};
      lane_we    = 4'b0001 << address[1:0];
    end else if (is_half) begin
      lane_wdata = {2{S_data[15:0]}};
      lane_we    = address[1] ? 4'b1100 : 4'b0011;
    end else begin
      lane_we    = 4'b1111;
    end
    if (!do_store) lane_we = 4'b0000;
  end

  data_memory_p #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_dmem (
    .clk  (clk),
    .re   (do_load),
    .we   (lane_we),
    .addr (address[AW+1:2]),
    .wdata(lane_wdata),
    .rdata(mem_rdata)
  );

  // Next-state and result-register logic; everything holds by default.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mis_d   = mis_q;
    tag_d   = tag_q;
    f3_d    = f3_q;
    off_d   = off_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tag_d = tag_in;
          if (is_memWrite) begin
            data_d  = 32'd0;
            mis_d   = ~aligned;
            state_d = RESP;
          end else if (is_memRead) begin
            if (aligned) begin
              f3_d    = funct3;
              off_d   = address[1:0];
              state_d = RD;
            end else begin
              data_d  = 32'd0;
              mis_d   = 1'b1;
              state_d = RESP;
            end
          end else begin
            data_d  = address;
            mis_d   = 1'b0;
            state_d = RESP;
          end
        end
      end
      RD: begin
        data_d  = load_extract(mem_rdata, off_q, f3_q);
        mis_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= 32'd0;
      mis_q   <= 1'b0;
      tag_q   <= '0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mis_q   <= mis_d;
      tag_q   <= tag_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

endmodule

// File: doc/mem_stage_p.md
# mem_stage_p

Parametrised memory-access pipeline stage with byte-enabled data memory, RISC-V sub-word loads and stores, and a valid/ready handshake on both sides. It sits between EX and WB and replaces the fixed word-only memory stage. It adds the following over that stage:
- byte, halfword and word accesses with sign or zero extension;
- misalignment detection;
- ALU-result pass-through;
- back-pressure from WB.

## Interface
Parameters:
- DATA_W, 32, data path width; only 32 is supported, an elaboration check enforces it.
- DEPTH_WORDS, 1024, memory depth in words; must be a power of two.
- TAG_W, 5, width of the side-band tag (destination register) carried through the stage.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX presents an operation.
- in_ready  out  1  stage can accept an operation.
- is_memRead  in  1  load operation.
- is_memWrite  in  1  store operation; has priority over is_memRead.
- funct3  in  3  access size and signedness: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- address  in  32  byte address, or ALU result for pass-through.
- S_data  in  32  store data; the active bytes are taken from the low bits.
- tag_in  in  TAG_W  side-band tag.
- out_valid  out  1  result available to WB.
- out_ready  in  1  WB accepts the result.
- data_out  out  32  load data, pass-through value, or 0.
- misaligned  out  1  the access was misaligned and was suppressed.
- tag_out  out  TAG_W  tag of the current result.

## Operation
- FSM states IDLE, RD, RESP, encoded as a 2-bit enum.
- in_ready = (state == IDLE).
- An operation is accepted on the edge where in_valid && in_ready.
- Word index is address[AW+1:2], with AW = $clog2(DEPTH_WORDS). Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Alignment rules:
  - halfword access requires address[0] == 0;
  - word access requires address[1:0] == 0;
  - byte access is always aligned;
  - reserved funct3 codes (011, 110, 111) are treated as word accesses.
- Store, aligned:
  - on the accept edge the memory writes with byte enables; SB writes 1 lane, SH 2 lanes, SW all 4 lanes;
  - the data is replicated into lanes selected by address[1:0];
  - FSM goes to RESP with data_out = 0 and misaligned = 0.
- Load, aligned:
  - the synchronous memory read is issued on the accept edge and FSM goes to RD;
  - in RD the selected byte or halfword is extracted and sign-extended (LB, LH) or zero-extended (LBU, LHU); the result is registered into data_out;
  - FSM goes to RESP.
- Misaligned load or store: no memory write, no read; FSM goes to RESP with misaligned = 1 and data_out = 0.
- Neither read nor write: FSM goes to RESP with data_out = address (ALU pass-through).
- tag_in is captured on accept and presented on tag_out in RESP.
- RESP: out_valid = 1. data_out, misaligned and tag_out hold stable until out_ready; on out_ready the FSM returns to IDLE.
- Memory contents are not reset; the initial contents are undefined (X in simulation).

## Timing
- Reset values (asynchronous): state = IDLE, out_valid = 0, data_out = 0, misaligned = 0, tag_out = 0.
- in_ready is 1 once reset is released.
- Latency from accept edge to out_valid high:
  - store, pass-through or misaligned: 1 cycle;
  - load: 2 cycles.
- Minimum spacing between accepts:
  - 2 cycles for non-load operations;
  - 3 cycles for loads, with out_ready held high.
- A load issued after a store observes that store's data: the store completes before in_ready rises again.
- out_ready low in RESP: the stage stalls indefinitely and all outputs stay constant.
- rst asserted mid-operation:
  - a store whose accept edge has already occurred stays written;
  - a pending load or result is discarded and out_valid drops immediately.
- in_valid while in_ready = 0 is ignored; EX must hold its inputs.
- is_memRead and is_memWrite both high: handled as a store.

## Structure
- Package mem_pkg contains:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum type;
  - the load-extract function (lane select plus extension).
- Sub-module data_memory_p (DEPTH_WORDS words, 4 byte-write-enables, synchronous read, no reset) holds the array.
- mem_stage_p contains the FSM, alignment check, lane steering and output registers.

## Test plan
- Reset then SW 0xDEADBEEF at address 0x10, then LW 0x10 -> out_valid 2 cycles after accept, data_out = 0xDEADBEEF, misaligned = 0, tag_out = tag_in.
- Four SB writes of 0x80, 0x01, 0x7F, 0xFF to addresses 0x20 through 0x23, then LB 0x20 -> 0xFFFFFF80, LBU 0x20 -> 0x00000080, LH 0x22 -> 0xFFFFFF7F, LHU 0x22 -> 0x0000FF7F, LW 0x20 -> 0xFF7F0180.
- SW 0x12345678 to 0x30, then SH 0xABCD to 0x31 -> misaligned = 1, no write; LW 0x30 then still returns 0x12345678. Separately, LW from 0x32 -> misaligned = 1, data_out = 0.
- Pass-through of 0xCAFEF00D (is_memRead = is_memWrite = 0) with out_ready held low for 5 cycles -> out_valid held high, data_out = 0xCAFEF00D throughout; in_ready = 0 until the handshake completes.
- With DEPTH_WORDS = 1024: SW 0x11111111 to 0x1000, then LW 0x0 -> 0x11111111 (address wrap).
- rst pulsed in RD after LW accept -> out_valid = 0 and data_out = 0 immediately; after reset, in_ready = 1 and a prior SW value remains readable.
